// File: rtl/speck_ti_share_loader.sv
// -----------------------------------------------------------------------------
// speck_ti_share_loader
//
// Feeds the 3-share threshold-implementation bit-serial Speck128/128 core.
// One plaintext block and one key are accepted as three Boolean shares each.
// The transfer uses a valid/ready handshake. All six share words are then
// streamed LSB-first under `we`. After that, `Start` is held for a fixed run
// window and a one-cycle `done` pulse reports completion.
//
// The shares are kept in separate lanes for the whole path. No logic ever
// combines two shares of the same value.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid / in_ready             capture handshake (capture while idle)
//   pt_a/b/c, key_a/b/c [WIDTH]     plaintext and key shares
//   cinit_a/b/c                     carry-init shares for the core's TI adder
//   data_ina/b/c, k_data_ina/b/c    serial share bits, valid while `we`=1
//   carry_init_a/b/c                captured carry-init shares (held)
//   we                              serial load strobe (WIDTH cycles)
//   Start                           core run enable (RUN_CYCLES cycles)
//   busy                            high while loading or running
//   done                            one-cycle pulse when the run window ends
// -----------------------------------------------------------------------------
module speck_ti_share_loader #(
   parameter int WIDTH      = 128,
   parameter int RUN_CYCLES = 3000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pt_a,
   input  logic [WIDTH-1:0] pt_b,
   input  logic [WIDTH-1:0] pt_c,
   input  logic [WIDTH-1:0] key_a,
   input  logic [WIDTH-1:0] key_b,
   input  logic [WIDTH-1:0] key_c,
   input  logic             cinit_a,
   input  logic             cinit_b,
   input  logic             cinit_c,
   output logic             data_ina,
   output logic             data_inb,
   output logic             data_inc,
   output logic             k_data_ina,
   output logic             k_data_inb,
   output logic             k_data_inc,
   output logic             carry_init_a,
   output logic             carry_init_b,
   output logic             carry_init_c,
   output logic             we,
   output logic             Start,
   output logic             busy,
   output logic             done
);

   localparam int             CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]  BIT_LAST = CW'(WIDTH - 1);
   localparam logic [15:0]    RUN_LAST = 16'(RUN_CYCLES - 1);
   localparam int             NLANE    = 6;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t            state_q, state_d;
   // Lane order: 0..2 = plaintext shares a/b/c, 3..5 = key shares a/b/c.
   logic [WIDTH-1:0]  word_in [NLANE];
   logic [WIDTH-1:0]  sr_q    [NLANE];
   logic [WIDTH-1:0]  sr_d    [NLANE];
   logic [NLANE-1:0]  ser_q, ser_d;
   logic [2:0]        cin_q, cin_d;
   logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [15:0]       run_cnt_q, run_cnt_d;
   logic              in_ready_q, in_ready_d;
   logic              we_q, we_d;
   logic              start_q, start_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   assign word_in[0] = pt_a;
   assign word_in[1] = pt_b;
   assign word_in[2] = pt_c;
   assign word_in[3] = key_a;
   assign word_in[4] = key_b;
   assign word_in[5] = key_c;

   always_comb begin
      state_d    = state_q;
      for (int i = 0; i < NLANE; i++) sr_d[i] = sr_q[i];
      ser_d      = '0;
      cin_d      = cin_q;
      bit_cnt_d  = bit_cnt_q;
      run_cnt_d  = run_cnt_q;
      in_ready_d = in_ready_q;
      we_d       = 1'b0;
      start_d    = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            if (in_valid) begin
               // Bit 0 goes straight to the output flop. The remainder is
               // parked in the shift register, so bit i leaves in load cycle i.
               for (int i = 0; i < NLANE; i++) begin
                  ser_d[i] = word_in[i][0];
                  sr_d[i]  = word_in[i] >> 1;
               end
               cin_d      = {cinit_c, cinit_b, cinit_a};
               bit_cnt_d  = '0;
               in_ready_d = 1'b0;
               busy_d     = 1'b1;
               we_d       = 1'b1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            if (bit_cnt_q == BIT_LAST) begin
               start_d   = 1'b1;
               run_cnt_d = '0;
               state_d   = S_RUN;
            end else begin
               we_d = 1'b1;
               for (int i = 0; i < NLANE; i++) begin
                  ser_d[i] = sr_q[i][0];
                  sr_d[i]  = sr_q[i] >> 1;
               end
               bit_cnt_d = bit_cnt_q + 1'b1;
            end
         end
         S_RUN: begin
            if (run_cnt_q == RUN_LAST) begin
               done_d     = 1'b1;
               busy_d     = 1'b0;
               in_ready_d = 1'b1;
               state_d    = S_IDLE;
            end else begin
               start_d   = 1'b1;
               run_cnt_d = run_cnt_q + 16'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         for (int i = 0; i < NLANE; i++) sr_q[i] <= '0;
         ser_q      <= '0;
         cin_q      <= '0;
         bit_cnt_q  <= '0;
         run_cnt_q  <= '0;
         in_ready_q <= 1'b1;
         we_q       <= 1'b0;
         start_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         for (int i = 0; i < NLANE; i++) sr_q[i] <= sr_d[i];
         ser_q      <= ser_d;
         cin_q      <= cin_d;
         bit_cnt_q  <= bit_cnt_d;
         run_cnt_q  <= run_cnt_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         start_q    <= start_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign we           = we_q;
   assign Start        = start_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign data_ina     = ser_q[0];
   assign data_inb     = ser_q[1];
   assign data_inc     = ser_q[2];
   assign k_data_ina   = ser_q[3];
   assign k_data_inb   = ser_q[4];
   assign k_data_inc   = ser_q[5];
   assign carry_init_a = cin_q[0];
   assign carry_init_b = cin_q[1];
   assign carry_init_c = cin_q[2];

endmodule

// File: tb/tb_speck_ti_share_loader.sv
// -----------------------------------------------------------------------------
// tb_speck_ti_share_loader
//
// Randomized stimulus against a behavioural model of the loader. The model
// tracks the operation only as "cycles elapsed since capture". From that count
// it derives every output: the load window is the first WIDTH cycles, the run
// window is the next RUN_CYCLES cycles, and done follows the run window. One
// process compares all outputs with the model on every falling edge. A few
// literal expectations pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_speck_ti_share_loader;

   localparam int W = 128;
   localparam int R = 5;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] pt_a, pt_b, pt_c, key_a, key_b, key_c;
   logic         cinit_a, cinit_b, cinit_c;
   logic         data_ina, data_inb, data_inc;
   logic         k_data_ina, k_data_inb, k_data_inc;
   logic         carry_init_a, carry_init_b, carry_init_c;
   logic         we, Start, busy, done;

   int n_checks = 0;
   int n_fail   = 0;

   speck_ti_share_loader #(.WIDTH(W), .RUN_CYCLES(R)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pt_a(pt_a), .pt_b(pt_b), .pt_c(pt_c),
      .key_a(key_a), .key_b(key_b), .key_c(key_c),
      .cinit_a(cinit_a), .cinit_b(cinit_b), .cinit_c(cinit_c),
      .data_ina(data_ina), .data_inb(data_inb), .data_inc(data_inc),
      .k_data_ina(k_data_ina), .k_data_inb(k_data_inb), .k_data_inc(k_data_inc),
      .carry_init_a(carry_init_a), .carry_init_b(carry_init_b),
      .carry_init_c(carry_init_c),
      .we(we), .Start(Start), .busy(busy), .done(done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- behavioural model ----------------
   bit           m_active;
   int           m_k;        // cycles elapsed since capture
   bit           m_done;
   logic [W-1:0] m_word [6];
   logic [2:0]   m_cin;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_active <= 1'b0;
         m_k      <= 0;
         m_done   <= 1'b0;
         m_cin    <= '0;
         for (int i = 0; i < 6; i++) m_word[i] <= '0;
      end else if (m_active) begin
         if (m_k + 1 == W + R) begin
            m_active <= 1'b0;
            m_k      <= 0;
            m_done   <= 1'b1;
         end else begin
            m_k    <= m_k + 1;
            m_done <= 1'b0;
         end
      end else begin
         m_done <= 1'b0;
         if (in_valid) begin
            m_active  <= 1'b1;
            m_k       <= 0;
            m_word[0] <= pt_a;  m_word[1] <= pt_b;  m_word[2] <= pt_c;
            m_word[3] <= key_a; m_word[4] <= key_b; m_word[5] <= key_c;
            m_cin     <= {cinit_c, cinit_b, cinit_a};
         end
      end
   end

   logic [13:0] exp_v, act_v;
   logic        m_ld;

   always_comb begin
      m_ld      = m_active && (m_k < W);
      exp_v     = '0;
      exp_v[13] = !m_active;
      exp_v[12] = m_ld;
      exp_v[11] = m_active && (m_k >= W);
      exp_v[10] = m_active;
      exp_v[9]  = m_done;
      for (int i = 0; i < 6; i++)
         exp_v[8-i] = m_ld ? m_word[i][m_k % W] : 1'b0;
      exp_v[2]  = m_cin[0];
      exp_v[1]  = m_cin[1];
      exp_v[0]  = m_cin[2];
   end

   assign act_v = {in_ready, we, Start, busy, done,
                   data_ina, data_inb, data_inc,
                   k_data_ina, k_data_inb, k_data_inc,
                   carry_init_a, carry_init_b, carry_init_c};

   // Per-cycle compare: {in_ready,we,Start,busy,done,d_a,d_b,d_c,k_a,k_b,k_c,ci_a,ci_b,ci_c}
   always @(negedge clk) begin
      n_checks++;
      if (act_v !== exp_v) begin
         n_fail++;
         $display("FAIL cycle_model t=%0t got=%b expected=%b", $time, act_v, exp_v);
      end
   end

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, exp);
      end
   endtask

   function automatic logic [W-1:0] rnd_word();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic rand_inputs();
      pt_a  = rnd_word(); pt_b  = rnd_word(); pt_c  = rnd_word();
      key_a = rnd_word(); key_b = rnd_word(); key_c = rnd_word();
      cinit_a = 1'($urandom); cinit_b = 1'($urandom); cinit_c = 1'($urandom);
   endtask

   // Call at a falling edge while idle. It returns at the falling edge of
   // load cycle 0, with the inputs already scrambled.
   task automatic issue_random();
      rand_inputs();
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rand_inputs();
   endtask

   // Samples from the current falling edge until done is seen. The cycle
   // budget is bounded. With pulse set, it fires stray in_valid strobes.
   task automatic run_block(input bit pulse, output int we_c, output int st_c,
                            output bit seen);
      we_c = 0; st_c = 0; seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (we)    we_c++;
         if (Start) st_c++;
         if (done) begin
            seen     = 1'b1;
            in_valid = 1'b0;
            break;
         end
         if (pulse && ($urandom_range(0, 3) == 0)) begin
            rand_inputs();
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      int wc, sc;
      bit seen;

      rst_n    = 1'b0;
      in_valid = 1'b0;
      rand_inputs();
      repeat (3) @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_outputs", 32'({we, Start, busy, done}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal block: identical shares, known key, cinit 1/0/1.
      pt_a  = 128'h6c617669757165207469206564616d20;
      pt_b  = pt_a; pt_c = pt_a;
      key_a = 128'h0f0e0d0c0b0a09080706050403020100;
      key_b = key_a; key_c = key_a;
      cinit_a = 1'b1; cinit_b = 1'b0; cinit_c = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      rand_inputs();
      chk("nom_cycle0_we", 32'(we), 32'd1);
      chk("nom_cycle0_bits", 32'({data_ina, data_inb, data_inc,
                                  k_data_ina, k_data_inb, k_data_inc}), 32'd0);
      chk("nom_carry_init", 32'({carry_init_a, carry_init_b, carry_init_c}), 32'b101);
      repeat (5) @(negedge clk);
      chk("nom_pt_bit5", 32'({data_ina, data_inb, data_inc}), 32'b111);
      repeat (3) @(negedge clk);
      chk("nom_key_bit8", 32'({k_data_ina, k_data_inb, k_data_inc}), 32'b111);
      run_block(1'b0, wc, sc, seen);
      chk("nom_we_cycles", 32'(wc), 32'd120);
      chk("nom_start_cycles", 32'(sc), 32'd5);
      chk("nom_done_seen", 32'(seen), 32'd1);
      chk("nom_done_in_ready", 32'({in_ready, busy}), 32'b10);
      @(negedge clk);
      chk("nom_after_done", 32'({done, busy, in_ready}), 32'b001);
      chk("nom_carry_held", 32'({carry_init_a, carry_init_b, carry_init_c}), 32'b101);

      // Independent random shares, with stray in_valid during LOAD and RUN.
      for (int blk = 0; blk < 3; blk++) begin
         issue_random();
         run_block(1'b1, wc, sc, seen);
         chk("rnd_we_cycles", 32'(wc), 32'd128);
         chk("rnd_start_cycles", 32'(sc), 32'd5);
         chk("rnd_done_seen", 32'(seen), 32'd1);
         @(negedge clk);
      end

      // Back-to-back: in_valid held high through done.
      issue_random();
      rand_inputs();
      in_valid = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (done) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("b2b_done_seen", 32'(seen), 32'd1);
      chk("b2b_done_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      rand_inputs();
      chk("b2b_reload_we", 32'({we, busy, in_ready}), 32'b110);
      run_block(1'b0, wc, sc, seen);
      chk("b2b_we_cycles", 32'(wc), 32'd128);
      chk("b2b_done2_seen", 32'(seen), 32'd1);
      @(negedge clk);

      // Reset at load bit 60, then a fresh block streams from bit 0.
      issue_random();
      repeat (60) @(negedge clk);
      chk("mid_load_we", 32'(we), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_load_we", 32'({we, busy, in_ready}), 32'b001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      issue_random();
      run_block(1'b0, wc, sc, seen);
      chk("post_rst_we_cycles", 32'(wc), 32'd128);
      chk("post_rst_done", 32'(seen), 32'd1);
      @(negedge clk);

      // Reset during RUN with Start active.
      issue_random();
      repeat (W + 2) @(negedge clk);
      chk("mid_run_start", 32'(Start), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      @(negedge clk);
      chk("rst_run_start", 32'({Start, done, busy, in_ready}), 32'b0001);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (R + 3) @(negedge clk);
      chk("no_done_after_rst", 32'({done, busy}), 32'b00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
